entrada_teclado: RTL and testbench

ENTRADA_TECLADO -- requirements
Module: entrada_teclado

---
 rtl/atm_pkg.sv | 27 ++
 rtl/entrada_teclado_if.sv | 23 ++
 rtl/entrada_teclado_antirrebote.sv | 107 ++++++++++
 rtl/entrada_teclado.sv | 97 +++++++++
 tb/tb_entrada_teclado.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, debounce states
// and the default filter/length parameters.
package atm_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int MAX_DIGITOS_DEF     = 9;

  localparam logic [3:0] COD_ENTER  = 4'd10;
  localparam logic [3:0] COD_BORRAR = 4'd11;

  typedef enum logic [1:0] {
    REPOSO            = 2'd0,
    FILTRO_PRESION    = 2'd1,
    PRESIONADA        = 2'd2,
    FILTRO_LIBERACION = 2'd3
  } estado_rebote_t;

  function automatic logic es_digito(input logic [3:0] cod);
    return (cod <= 4'd9);
  endfunction

  // acum*10 + d built from shifts; callers guarantee the result fits 32 bits
  function automatic logic [31:0] mul10_suma(input logic [31:0] acum, input logic [3:0] d);
    return (acum << 3) + (acum << 1) + {28'd0, d};
  endfunction

endpackage

// File: rtl/entrada_teclado_if.sv
// Keypad-side inputs and decoded outputs of entrada_teclado, grouped as one bus.
interface entrada_teclado_if;

  logic        tecla_valida;
  logic [3:0]  tecla_cod;
  logic        modo_monto;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        desbordamiento;

  modport master (
    output tecla_valida, tecla_cod, modo_monto,
    input  digito, digito_stb, monto, monto_stb, desbordamiento
  );

  modport slave (
    input  tecla_valida, tecla_cod, modo_monto,
    output digito, digito_stb, monto, monto_stb, desbordamiento
  );

endinterface

// File: rtl/entrada_teclado_antirrebote.sv
// Two-flop synchronizer plus press/release debounce filter; emits one registered
// evento pulse with its key code per accepted press.
module antirrebote
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tecla_valida,
  input  logic [3:0] i_tecla_cod,
  output logic       o_evento,
  output logic [3:0] o_evento_cod
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_CYCLES);

  logic           r_valida_m;
  logic           r_valida_s;
  logic [3:0]     r_cod_m;
  logic [3:0]     r_cod_s;
  estado_rebote_t r_estado;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_cod_cap;
  logic           r_evento;
  logic [3:0]     r_evento_cod;

  // Synchronize raw keypad level and code into the clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valida_m <= 1'b0;
      r_valida_s <= 1'b0;
      r_cod_m    <= 4'd0;
      r_cod_s    <= 4'd0;
    end else begin
      r_valida_m <= i_tecla_valida;
      r_valida_s <= r_valida_m;
      r_cod_m    <= i_tecla_cod;
      r_cod_s    <= r_cod_m;
    end
  end

  // Debounce FSM; the event fires only on the filtered press edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado     <= REPOSO;
      r_cnt        <= '0;
      r_cod_cap    <= 4'd0;
      r_evento     <= 1'b0;
      r_evento_cod <= 4'd0;
    end else begin
      r_evento <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (r_valida_s) begin
            r_estado  <= FILTRO_PRESION;
            r_cod_cap <= r_cod_s;
            r_cnt     <= CW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        FILTRO_PRESION: begin
          if (!r_valida_s || (r_cod_s != r_cod_cap)) begin
            r_estado <= REPOSO;
            r_cnt    <= '0;
          end else if (r_cnt == CNT_FIN) begin
            r_estado     <= PRESIONADA;
            r_cnt        <= '0;
            r_evento     <= 1'b1;
            r_evento_cod <= r_cod_cap;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESIONADA: begin
          if (!r_valida_s) begin
            r_estado <= FILTRO_LIBERACION;
            r_cnt    <= CW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        FILTRO_LIBERACION: begin
          if (r_valida_s) begin
            r_estado <= PRESIONADA;
            r_cnt    <= '0;
          end else if (r_cnt == CNT_FIN) begin
            r_estado <= REPOSO;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_estado <= REPOSO;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign o_evento     = r_evento;
  assign o_evento_cod = r_evento_cod;

endmodule

// File: rtl/entrada_teclado.sv
// ATM keypad front end: debounced key events become PIN digit strobes or a
// decimal amount accumulator committed with ENTER.
module entrada_teclado
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int MAX_DIGITOS     = MAX_DIGITOS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  entrada_teclado_if.slave   bus
);

  localparam int CDW = $clog2(MAX_DIGITOS + 1);
  localparam logic [CDW-1:0] CUENTA_MAX = CDW'(MAX_DIGITOS);

  logic           w_evento;
  logic [3:0]     w_evento_cod;
  logic           w_cambio_modo;

  logic           r_modo_prev;
  logic [31:0]    r_acum;
  logic [CDW-1:0] r_cuenta;
  logic [3:0]     r_digito;
  logic           r_digito_stb;
  logic [31:0]    r_monto;
  logic           r_monto_stb;
  logic           r_desbordamiento;

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_antirrebote (
    .clk            (clk),
    .reset          (reset),
    .i_tecla_valida (bus.tecla_valida),
    .i_tecla_cod    (bus.tecla_cod),
    .o_evento       (w_evento),
    .o_evento_cod   (w_evento_cod)
  );

  assign w_cambio_modo = (bus.modo_monto != r_modo_prev);

  // Key decode, amount accumulator and registered strobes; a mode change
  // clears the accumulator and swallows any event in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_modo_prev      <= 1'b0;
      r_acum           <= 32'd0;
      r_cuenta         <= '0;
      r_digito         <= 4'd0;
      r_digito_stb     <= 1'b0;
      r_monto          <= 32'd0;
      r_monto_stb      <= 1'b0;
      r_desbordamiento <= 1'b0;
    end else begin
      r_modo_prev      <= bus.modo_monto;
      r_digito_stb     <= 1'b0;
      r_monto_stb      <= 1'b0;
      r_desbordamiento <= 1'b0;
      if (w_cambio_modo) begin
        r_acum   <= 32'd0;
        r_cuenta <= '0;
      end else if (w_evento) begin
        if (!bus.modo_monto) begin
          if (es_digito(w_evento_cod)) begin
            r_digito     <= w_evento_cod;
            r_digito_stb <= 1'b1;
          end
        end else if (es_digito(w_evento_cod)) begin
          if (r_cuenta < CUENTA_MAX) begin
            r_acum   <= mul10_suma(r_acum, w_evento_cod);
            r_cuenta <= r_cuenta + 1'b1;
          end else begin
            r_desbordamiento <= 1'b1;
          end
        end else if (w_evento_cod == COD_ENTER) begin
          if (r_cuenta != '0) begin
            r_monto     <= r_acum;
            r_monto_stb <= 1'b1;
            r_acum      <= 32'd0;
            r_cuenta    <= '0;
          end
        end else if (w_evento_cod == COD_BORRAR) begin
          r_acum   <= 32'd0;
          r_cuenta <= '0;
        end
      end
    end
  end

  assign bus.digito         = r_digito;
  assign bus.digito_stb     = r_digito_stb;
  assign bus.monto          = r_monto;
  assign bus.monto_stb      = r_monto_stb;
  assign bus.desbordamiento = r_desbordamiento;

endmodule

// File: tb/tb_entrada_teclado.sv
// Directed bench for entrada_teclado: a key-press vector table plus hand-written
// bounce, reset and mode-change sequences.
module tb_entrada_teclado;

  localparam int D = 4;

  typedef struct {
    logic        modo;
    logic [3:0]  cod;
    int          e_dig;
    int          e_mon;
    int          e_ovf;
    logic [31:0] val;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   n_dig = 0;
  int   n_mon = 0;
  int   n_ovf = 0;
  int   n_multi = 0;
  logic [3:0]  last_dig = 4'd0;
  logic [31:0] last_mon = 32'd0;
  vec_t vq[$];

  always #5 clk = ~clk;

  entrada_teclado_if bus();

  entrada_teclado #(.DEBOUNCE_CYCLES(D), .MAX_DIGITOS(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Strobe monitor sampled on the falling edge
  always @(negedge clk) begin
    if (bus.digito_stb) begin
      n_dig    <= n_dig + 1;
      last_dig <= bus.digito;
    end
    if (bus.monto_stb) begin
      n_mon    <= n_mon + 1;
      last_mon <= bus.monto;
    end
    if (bus.desbordamiento) n_ovf <= n_ovf + 1;
    if ((int'(bus.digito_stb) + int'(bus.monto_stb) + int'(bus.desbordamiento)) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_key(input logic [3:0] cod, input int hold, input int rel);
    @(negedge clk);
    bus.tecla_valida = 1'b1;
    bus.tecla_cod    = cod;
    repeat (hold) @(negedge clk);
    bus.tecla_valida = 1'b0;
    repeat (rel) @(negedge clk);
    #1;
  endtask

  function automatic void add_vec(logic m, logic [3:0] c, int ed, int em, int eo, logic [31:0] v);
    vec_t t;
    t.modo = m; t.cod = c; t.e_dig = ed; t.e_mon = em; t.e_ovf = eo; t.val = v;
    vq.push_back(t);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, m0, o0, lat;
    logic got;
    logic [31:0] hold_exp;

    bus.tecla_valida = 1'b0;
    bus.tecla_cod    = 4'd0;
    bus.modo_monto   = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset digito", {28'd0, bus.digito}, 32'd0);
    check("reset digito_stb", {31'd0, bus.digito_stb}, 32'd0);
    check("reset monto", bus.monto, 32'd0);
    check("reset monto_stb", {31'd0, bus.monto_stb}, 32'd0);
    check("reset desbordamiento", {31'd0, bus.desbordamiento}, 32'd0);

    // PIN mode: digits forwarded, control and unused codes ignored
    add_vec(1'b0, 4'd3, 1, 0, 0, 32'd3);
    add_vec(1'b0, 4'd0, 1, 0, 0, 32'd0);
    add_vec(1'b0, 4'd9, 1, 0, 0, 32'd9);
    add_vec(1'b0, 4'd10, 0, 0, 0, 32'd0);
    add_vec(1'b0, 4'd11, 0, 0, 0, 32'd0);
    add_vec(1'b0, 4'd13, 0, 0, 0, 32'd0);
    add_vec(1'b0, 4'd15, 0, 0, 0, 32'd0);
    // Amount mode: 1250, empty ENTER, BORRAR, mode-change clear
    add_vec(1'b1, 4'd1, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd2, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd5, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd0, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd10, 0, 1, 0, 32'd1250);
    add_vec(1'b1, 4'd10, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd4, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd4, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd11, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd3, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd10, 0, 1, 0, 32'd3);
    add_vec(1'b1, 4'd7, 0, 0, 0, 32'd0);
    add_vec(1'b0, 4'd2, 1, 0, 0, 32'd2);
    add_vec(1'b1, 4'd10, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd12, 0, 0, 0, 32'd0);
    for (int k = 0; k < 9; k++) add_vec(1'b1, 4'd9, 0, 0, 0, 32'd0);
    add_vec(1'b1, 4'd9, 0, 0, 1, 32'd0);
    add_vec(1'b1, 4'd10, 0, 1, 0, 32'd999999999);

    hold_exp = 32'd0;
    foreach (vq[i]) begin
      if (bus.modo_monto !== vq[i].modo) begin
        @(negedge clk);
        bus.modo_monto = vq[i].modo;
        repeat (3) @(negedge clk);
      end
      d0 = n_dig; m0 = n_mon; o0 = n_ovf;
      pulse_key(vq[i].cod, 12, 12);
      check($sformatf("v%0d digito_stb count", i), n_dig - d0, vq[i].e_dig);
      check($sformatf("v%0d monto_stb count", i), n_mon - m0, vq[i].e_mon);
      check($sformatf("v%0d desbordamiento count", i), n_ovf - o0, vq[i].e_ovf);
      if (vq[i].e_dig != 0) check($sformatf("v%0d digito", i), {28'd0, last_dig}, vq[i].val);
      if (vq[i].e_mon != 0) begin
        check($sformatf("v%0d monto", i), last_mon, vq[i].val);
        hold_exp = vq[i].val;
      end
      check($sformatf("v%0d monto held", i), bus.monto, hold_exp);
    end

    // Bounce: two one-cycle glitches, then key 7 held; latency from the stable press
    @(negedge clk);
    bus.modo_monto = 1'b0;
    repeat (3) @(negedge clk);
    d0 = n_dig;
    bus.tecla_cod = 4'd7;
    bus.tecla_valida = 1'b1; @(negedge clk);
    bus.tecla_valida = 1'b0; @(negedge clk);
    bus.tecla_valida = 1'b1; @(negedge clk);
    bus.tecla_valida = 1'b0; @(negedge clk);
    bus.tecla_valida = 1'b1;
    got = 1'b0; lat = 0;
    @(posedge clk);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.digito_stb) begin
        got = 1'b1;
        lat = k;
      end else begin
        @(posedge clk);
      end
    end
    check("bounce strobe seen", {31'd0, got}, 32'd1);
    check("bounce latency", lat, D + 3);
    repeat (12) @(negedge clk);
    bus.tecla_valida = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("bounce strobe count", n_dig - d0, 32'd1);
    check("bounce digito", {28'd0, last_dig}, 32'd7);

    // Reset during press filter of key 5, key released while in reset
    d0 = n_dig; m0 = n_mon;
    @(negedge clk);
    bus.tecla_cod = 4'd5;
    bus.tecla_valida = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midpress reset digito", {28'd0, bus.digito}, 32'd0);
    check("midpress reset monto", bus.monto, 32'd0);
    check("midpress reset strobes",
          {29'd0, bus.digito_stb, bus.monto_stb, bus.desbordamiento}, 32'd0);
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("midpress no strobe", (n_dig - d0) + (n_mon - m0), 32'd0);

    // Reset during press filter with key still held: full filter afterwards
    d0 = n_dig;
    @(negedge clk);
    bus.tecla_valida = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1;
    check("held after reset early", n_dig - d0, 32'd0);
    repeat (10) @(negedge clk);
    bus.tecla_valida = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("held after reset count", n_dig - d0, 32'd1);
    check("held after reset digito", {28'd0, last_dig}, 32'd5);

    // Key 6 with modo_monto 0->1 in the event cycle: event dropped
    d0 = n_dig; m0 = n_mon; o0 = n_ovf;
    @(negedge clk);
    bus.tecla_cod = 4'd6;
    bus.tecla_valida = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    bus.modo_monto = 1'b1;
    repeat (10) @(negedge clk);
    bus.tecla_valida = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("modechg digito_stb", n_dig - d0, 32'd0);
    check("modechg other strobes", (n_mon - m0) + (n_ovf - o0), 32'd0);
    pulse_key(4'd10, 12, 12);
    check("modechg enter empty", n_mon - m0, 32'd0);
    pulse_key(4'd8, 12, 12);
    pulse_key(4'd10, 12, 12);
    check("modechg enter count", n_mon - m0, 32'd1);
    check("modechg monto", last_mon, 32'd8);

    check("strobe exclusivity", n_multi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
